// File: rtl/instruction_memory_responder.sv
// Instruction-fetch refill responder: reads one cache block from a fixed-latency
// pipelined SRAM and streams it back one word per cycle, flagging the last beat.
module instruction_memory_responder #(
    parameter int unsigned  BLOCK_SIZE  = 32,
    parameter logic [31:0]  MEMORY_BASE = 32'h0000_0000,
    parameter int unsigned  MEMORY_SIZE = 2**16,
    parameter int unsigned  MEM_LATENCY = 2,
    localparam int unsigned MEM_AW      = $clog2(MEMORY_SIZE / 4)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              request_i,
    input  logic [31:0]       address_i,
    input  logic              abort_i,
    output logic              ready_o,
    output logic [31:0]       data_o,
    output logic              valid_o,
    output logic              last_o,
    output logic              error_o,
    output logic              mem_read_o,
    output logic [MEM_AW-1:0] mem_address_o,
    input  logic [31:0]       mem_data_i
);

    localparam int unsigned      BLOCK_WORDS = BLOCK_SIZE / 4;
    localparam int unsigned      CNT_W       = $clog2(BLOCK_WORDS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [31:0]      BLOCK_MASK  = ~(32'(BLOCK_SIZE) - 32'd1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_e;

    // Per-beat tag travelling alongside the SRAM read latency.
    typedef struct packed {
        logic live;
        logic last;
        logic err;
    } tag_t;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [MEM_AW-1:0]      word_base_q, word_base_d;
    logic                   in_range_q, in_range_d;
    tag_t [MEM_LATENCY-1:0] pipe_q, pipe_d;
    logic [32:0]            offset_c;
    logic                   pipe_busy_c;
    tag_t                   pipe_out_c;

    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        word_base_d   = word_base_q;
        in_range_d    = in_range_q;
        ready_o       = 1'b0;
        mem_read_o    = 1'b0;
        mem_address_o = '0;
        pipe_busy_c   = 1'b0;
        // 33-bit offset so a block below MEMORY_BASE shows up as a borrow.
        offset_c      = {1'b0, address_i & BLOCK_MASK} - {1'b0, MEMORY_BASE};

        pipe_d[0] = '0;
        for (int i = 1; i < int'(MEM_LATENCY); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        unique case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (request_i && !abort_i) begin
                    word_base_d = MEM_AW'(offset_c[31:2]);
                    in_range_d  = !offset_c[32] && (offset_c[31:0] < 32'(MEMORY_SIZE));
                    beat_cnt_d  = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (abort_i) begin
                    state_d = DRAIN;
                end else begin
                    pipe_d[0].live = 1'b1;
                    pipe_d[0].last = (beat_cnt_q == LAST_BEAT);
                    pipe_d[0].err  = !in_range_q;
                    mem_read_o     = in_range_q;
                    if (in_range_q) begin
                        mem_address_o = word_base_q + MEM_AW'(beat_cnt_q);
                    end
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
            end
            default: state_d = IDLE;
        endcase

        // Abort kills every in-flight beat, including the one leaving the pipe now.
        if (abort_i) begin
            for (int i = 0; i < int'(MEM_LATENCY); i++) begin
                pipe_d[i].live = 1'b0;
            end
        end

        for (int i = 0; i < int'(MEM_LATENCY); i++) begin
            pipe_busy_c = pipe_busy_c | pipe_d[i].live;
        end

        if (state_q == DRAIN && !pipe_busy_c) begin
            state_d = IDLE;
        end
    end

    assign pipe_out_c = pipe_q[MEM_LATENCY-1];
    assign valid_o    = pipe_out_c.live && !abort_i;
    assign last_o     = valid_o && pipe_out_c.last;
    assign error_o    = valid_o && pipe_out_c.err;
    assign data_o     = (valid_o && !pipe_out_c.err) ? mem_data_i : 32'h0000_0000;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            word_base_q <= '0;
            in_range_q  <= 1'b0;
            pipe_q      <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            word_base_q <= word_base_d;
            in_range_q  <= in_range_d;
            pipe_q      <= pipe_d;
        end
    end

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Bench for instruction_memory_responder: table of refill bursts plus hand-written
// abort / busy / reset sequences, checked cycle-exactly against a beat scoreboard.
module tb_instruction_memory_responder;

    localparam int BW  = 8;
    localparam int LAT = 2;
    localparam int AW  = 14;

    typedef struct {
        logic [31:0]   addr;
        int            abort_at;
        logic [31:0]   first;
        logic [AW-1:0] word;
        logic          err;
        int            beats;
        int            reads;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        last;
        logic        err;
    } beat_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
    } rd_t;

    logic          clk_i;
    logic          rst_n_i;
    logic          request_i;
    logic [31:0]   address_i;
    logic          abort_i;
    logic          ready_o;
    logic [31:0]   data_o;
    logic          valid_o;
    logic          last_o;
    logic          error_o;
    logic          mem_read_o;
    logic [AW-1:0] mem_address_o;
    logic [31:0]   mem_data_i;
    logic [31:0]   sram_q0;
    logic [31:0]   sram_q1;

    int    checks;
    int    errors;
    int    cyc;
    int    busy_from;
    int    ready_at;
    int    dc_cyc;
    beat_t beat_q[$];
    rd_t   rd_q[$];
    vec_t  vecs[7];

    instruction_memory_responder #(
        .BLOCK_SIZE (32),
        .MEMORY_BASE(32'h0000_0000),
        .MEMORY_SIZE(2**16),
        .MEM_LATENCY(LAT)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .request_i    (request_i),
        .address_i    (address_i),
        .abort_i      (abort_i),
        .ready_o      (ready_o),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .last_o       (last_o),
        .error_o      (error_o),
        .mem_read_o   (mem_read_o),
        .mem_address_o(mem_address_o),
        .mem_data_i   (mem_data_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // SRAM model: mem[i] = C0DE_0000 + i, two-cycle read pipeline.
    always @(posedge clk_i) begin
        sram_q1 <= sram_q0;
        sram_q0 <= mem_read_o ? (32'hC0DE_0000 + 32'(mem_address_o)) : 32'hDEAD_BEEF;
    end
    assign mem_data_i = sram_q1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Sample on the falling edge, then advance to just after the next rising edge.
    task automatic step();
        beat_t b;
        rd_t   r;
        logic  exp_rdy;
        @(negedge clk_i);
        exp_rdy = (cyc < busy_from) || (cyc >= ready_at);
        if (cyc != dc_cyc) chk("ready", 64'(ready_o), 64'(exp_rdy));

        while (beat_q.size() > 0 && beat_q[0].cyc < cyc) begin
            b = beat_q.pop_front();
            checks++;
            errors++;
            $display("FAIL beat_missing at cycle %0d: got no beat expected data %0h", b.cyc, b.data);
        end
        if (valid_o) begin
            if (beat_q.size() > 0 && beat_q[0].cyc == cyc) begin
                b = beat_q.pop_front();
                chk("beat_data", 64'(data_o), 64'(b.data));
                chk("beat_last_err", 64'({last_o, error_o}), 64'({b.last, b.err}));
            end else begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected at cycle %0d: got data %0h expected no beat", cyc, data_o);
            end
        end else begin
            chk("idle_outputs", 64'({last_o, error_o, data_o}), 64'd0);
        end

        while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
            r = rd_q.pop_front();
            checks++;
            errors++;
            $display("FAIL read_missing at cycle %0d: got no read expected address %0h", r.cyc, r.addr);
        end
        if (mem_read_o) begin
            if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
                r = rd_q.pop_front();
                chk("mem_address", 64'(mem_address_o), 64'(r.addr));
            end else begin
                checks++;
                errors++;
                $display("FAIL read_unexpected at cycle %0d: got read of %0h expected none", cyc, mem_address_o);
            end
        end

        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    // Push the beats and reads a request accepted in the current cycle must produce.
    task automatic expect_burst(input vec_t v);
        beat_t b;
        rd_t   r;
        for (int k = 0; k < v.reads; k++) begin
            r.cyc  = cyc + 1 + k;
            r.addr = v.word + AW'(k);
            rd_q.push_back(r);
        end
        for (int k = 0; k < v.beats; k++) begin
            b.cyc  = cyc + 1 + k + LAT;
            b.data = v.err ? 32'h0 : v.first + 32'(k);
            b.last = (k == BW - 1);
            b.err  = v.err;
            beat_q.push_back(b);
        end
        busy_from = cyc + 1;
        if (v.abort_at > 0) begin
            ready_at = cyc + v.abort_at + 2;
            dc_cyc   = cyc + v.abort_at + 1;
        end else begin
            ready_at = cyc + BW + LAT + 1;
            dc_cyc   = -1;
        end
    endtask

    task automatic run_burst(input vec_t v);
        int c0;
        c0 = cyc;
        expect_burst(v);
        request_i = 1'b1;
        address_i = v.addr;
        abort_i   = 1'b0;
        step();
        request_i = 1'b0;
        address_i = $urandom();
        while (cyc < ready_at) begin
            abort_i = (v.abort_at > 0) && (cyc == c0 + v.abort_at);
            step();
        end
        abort_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected end of test by 100000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        int   c0;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        busy_from = 0;
        ready_at  = 0;
        dc_cyc    = -1;
        vecs[0] = '{32'h0000_0040, 0, 32'hC0DE_0010, 14'd16,     1'b0, 8, 8};
        vecs[1] = '{32'h0000_005C, 0, 32'hC0DE_0010, 14'd16,     1'b0, 8, 8};
        vecs[2] = '{32'h0001_0000, 0, 32'h0,         14'd0,      1'b1, 8, 0};
        vecs[3] = '{32'h0000_FFE0, 0, 32'hC0DE_3FF8, 14'h3FF8,   1'b0, 8, 8};
        vecs[4] = '{32'h0000_0040, 4, 32'hC0DE_0010, 14'd16,     1'b0, 1, 3};
        vecs[5] = '{32'h0000_0080, 0, 32'hC0DE_0020, 14'd32,     1'b0, 8, 8};
        vecs[6] = '{32'hFFFF_FFFC, 0, 32'h0,         14'd0,      1'b1, 8, 0};

        rst_n_i   = 1'b0;
        request_i = 1'b0;
        address_i = 32'h0;
        abort_i   = 1'b0;
        @(posedge clk_i);
        #1;
        step();
        chk("reset_ready", 64'(ready_o), 64'd1);
        chk("reset_read", 64'({mem_read_o, valid_o, last_o, error_o}), 64'd0);
        chk("reset_address_data", 64'({mem_address_o, data_o}), 64'd0);
        rst_n_i = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            run_burst(vecs[i]);
        end

        // Abort in IDLE outranks a simultaneous request.
        request_i = 1'b1;
        abort_i   = 1'b1;
        address_i = 32'h0000_0040;
        step();
        request_i = 1'b0;
        abort_i   = 1'b0;
        repeat (4) step();

        // Request held high: second address waits until ready_o returns.
        c0 = cyc;
        v  = '{32'h0000_0000, 0, 32'hC0DE_0000, 14'd0, 1'b0, 8, 8};
        expect_burst(v);
        request_i = 1'b1;
        address_i = 32'h0000_0000;
        step();
        address_i = 32'h0000_0020;
        while (cyc < c0 + 11) step();
        v = '{32'h0000_0020, 0, 32'hC0DE_0008, 14'd8, 1'b0, 8, 8};
        expect_burst(v);
        while (cyc < c0 + 22) step();
        request_i = 1'b0;
        repeat (2) step();

        // Asynchronous reset in the middle of a burst.
        c0 = cyc;
        v  = '{32'h0000_0040, 0, 32'hC0DE_0010, 14'd16, 1'b0, 3, 5};
        expect_burst(v);
        ready_at  = c0 + 6;
        request_i = 1'b1;
        address_i = 32'h0000_0040;
        step();
        request_i = 1'b0;
        while (cyc < c0 + 6) step();
        rst_n_i = 1'b0;
        step();
        rst_n_i = 1'b1;
        repeat (4) step();
        run_burst(vecs[0]);

        repeat (4) step();
        chk("beats_outstanding", 64'(beat_q.size()), 64'd0);
        chk("reads_outstanding", 64'(rd_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_memory_responder.md
Name: instruction_memory_responder

Overview:
- Responder end of the instruction-fetch load channel.
- Accepts a cache-line refill request from the instruction cache fetch controller and reads BLOCK_WORDS consecutive words from a pipelined on-chip instruction SRAM with fixed read latency.
- Returns the words to the requester one beat per cycle, in order, flagging the last beat.
- Sits between the instruction cache complex and the boot/program memory.

Parameters:
- BLOCK_SIZE, 32, cache block size in bytes (power of two, ≥8); BLOCK_WORDS = BLOCK_SIZE/4.
- MEMORY_BASE, 32'h0000_0000, byte base address of the instruction memory (BLOCK_SIZE-aligned).
- MEMORY_SIZE, 2**16, memory size in bytes (power of two); MEM_AW = $clog2(MEMORY_SIZE/4).
- MEM_LATENCY, 2, cycles from mem_read_o to mem_data_i valid (≥1).

Ports:
- clk_i  input  1  clock
- rst_n_i  input  1  reset, asynchronous, active-low
- request_i  input  1  refill request; sampled only when ready_o=1
- address_i  input  32  any byte address inside the requested block
- abort_i  input  1  cancel the current burst (cache invalidate / flush)
- ready_o  output  1  idle, can accept a request
- data_o  output  32  returned instruction word
- valid_o  output  1  data_o valid this cycle (no backpressure)
- last_o  output  1  qualifies the final beat of a burst
- error_o  output  1  beat belongs to an out-of-range burst
- mem_read_o  output  1  SRAM read strobe
- mem_address_o  output  MEM_AW  SRAM word address
- mem_data_i  input  32  SRAM read data, valid MEM_LATENCY cycles after strobe

Behaviour:
- Reset values: ready_o=1, all other outputs 0. FSM=IDLE, counters and in-flight pipe cleared. Reset mid-burst drops every in-flight beat; no valid_o after reset release until a new request.
- Base address: base = address_i & ~(BLOCK_SIZE-1), latched on acceptance. Beats always start at the block base; no critical-word-first.
- Range check: in_range = (base >= MEMORY_BASE) && (base < MEMORY_BASE+MEMORY_SIZE), computed once at acceptance.
- Word address: mem_address_o = (base - MEMORY_BASE)[MEM_AW+1:2] + beat_cnt. beat_cnt is $clog2(BLOCK_WORDS)+1 bits and cannot wrap past the block.
- FSM:
  - IDLE: ready_o=1. On request_i (abort_i=0), latch base and in_range, beat_cnt=0, go to ISSUE. Acceptance takes 1 cycle.
  - ISSUE: ready_o=0. Each cycle push one tag into an in-flight shift pipe of depth MEM_LATENCY. The tag is {live, last, err}, with last=(beat_cnt==BLOCK_WORDS-1) and err=!in_range.
    - If in_range, assert mem_read_o; otherwise mem_read_o=0 (no SRAM access).
    - beat_cnt++. After pushing beat BLOCK_WORDS-1, go to DRAIN.
  - DRAIN: no new reads; wait until the in-flight pipe is empty, then go to IDLE.
- Output stage: valid_o = pipe_out.live. data_o = err ? 32'h0000_0000 : mem_data_i. last_o and error_o are taken from the tag and are 0 whenever valid_o=0.
- Timing, request accepted at cycle 0:
  - reads issue at cycles 1..BLOCK_WORDS;
  - beat k is valid at cycle 1+k+MEM_LATENCY;
  - last_o at cycle BLOCK_WORDS+MEM_LATENCY;
  - ready_o=1 at cycle BLOCK_WORDS+MEM_LATENCY+1.
- request_i while ready_o=0 is ignored; it is not queued.
- abort_i:
  - in ISSUE or DRAIN: stop issuing immediately that cycle; clear the live bit of every in-flight tag, so no further valid_o including that cycle's output; go to DRAIN. ready_o returns once the pipe is empty (≤ MEM_LATENCY cycles).
  - in IDLE: abort_i has priority over a simultaneous request_i; the request is dropped.
- Back-to-back bursts: a new request may be accepted in the cycle ready_o returns to 1. No overlap between bursts.

Test Plan:
- Setup for all scenarios: BLOCK_SIZE=32, MEM_LATENCY=2, MEMORY_BASE=0, MEMORY_SIZE=64KiB, mem[i]=32'hC0DE_0000+i.
- Aligned refill: request address_i=32'h0000_0040 at cycle 0 -> data_o 32'hC0DE_0010..32'hC0DE_0017 valid on cycles 3..10; last_o only at cycle 10; ready_o=1 at cycle 11; mem_address_o 16..23.
- Unaligned request: address_i=32'h0000_005C -> same burst as base 0x40, first beat 32'hC0DE_0010; error_o=0 throughout.
- Out of range: address_i=32'h0001_0000 -> 8 beats of 32'h0 with error_o=1; mem_read_o never asserted; last_o at cycle 10.
- Abort: abort_i pulse at cycle 4 of a burst -> beats 0 and 1 (cycles 3, 4; the cycle-4 beat is suppressed) … only the cycle-3 beat is delivered; no valid_o after cycle 3; ready_o=1 within 2 cycles of abort; a new request then completes normally.
- Busy and back-to-back: request_i held high continuously with addresses 0x00 then 0x20 -> the second request is ignored until ready_o; the second burst starts at cycle 11 and delivers 32'hC0DE_0008..F. A request during a burst never perturbs the data.
- Async reset at cycle 6 mid-burst -> outputs 0 immediately; ready_o=1 after release; no stale beats.
